// File: rtl/cgra_obi_master_cut.sv
// Register cut between a CGRA OBI master and an external bus port.
// Holds one request slot, registers responses, and limits transactions in flight.
module cgra_obi_master_cut #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        s_req_i,
  output logic        s_gnt_o,
  input  logic [31:0] s_addr_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_be_i,
  input  logic [31:0] s_wdata_i,
  output logic        s_rvalid_o,
  output logic [31:0] s_rdata_o,

  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,

  output logic        busy_o,
  output logic        err_o
);

  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     INF_MAX = (CW + 1)'(MAX_OUTSTANDING);

  logic          slot_valid;
  logic [CW-1:0] cnt;
  logic [CW:0]   inflight;
  logic          m_hs;
  logic          s_hs;

  assign inflight = {1'b0, cnt} + {{CW{1'b0}}, slot_valid};
  assign m_hs     = slot_valid & m_gnt_i;

  // A response arriving this cycle frees a credit that a new request may reuse immediately.
  assign s_gnt_o  = ~rst_i & s_req_i & (~slot_valid | m_gnt_i)
                  & ((inflight < INF_MAX) | m_rvalid_i);
  assign s_hs     = s_req_i & s_gnt_o;

  assign m_req_o  = slot_valid;
  assign busy_o   = slot_valid | (cnt != '0) | s_rvalid_o;

  // NOTE: all state, including the data fields, is cleared so outputs read zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid <= 1'b0;
      m_addr_o   <= '0;
      m_we_o     <= 1'b0;
      m_be_o     <= '0;
      m_wdata_o  <= '0;
      cnt        <= '0;
      s_rvalid_o <= 1'b0;
      s_rdata_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      if (s_hs) begin
        slot_valid <= 1'b1;
        m_addr_o   <= s_addr_i;
        m_we_o     <= s_we_i;
        m_be_o     <= s_be_i;
        m_wdata_o  <= s_wdata_i;
      end else if (m_hs) begin
        slot_valid <= 1'b0;
      end

      s_rvalid_o <= m_rvalid_i;
      s_rdata_o  <= m_rdata_i;

      // A response with nothing outstanding is forwarded but flagged; the counter never wraps.
      if (m_rvalid_i && (cnt == '0)) begin
        err_o <= 1'b1;
      end

      if (m_hs && !m_rvalid_i) begin
        if (cnt == CNT_MAX) begin
          err_o <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (!m_hs && m_rvalid_i && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cgra_obi_master_cut.sv
// Directed bench for cgra_obi_master_cut with request and response scoreboards.
// Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
module tb_cgra_obi_master_cut;

  logic        clk_i;
  logic        rst_i;
  logic        s_req_i;
  logic        s_gnt_o;
  logic [31:0] s_addr_i;
  logic        s_we_i;
  logic [3:0]  s_be_i;
  logic [31:0] s_wdata_i;
  logic        s_rvalid_o;
  logic [31:0] s_rdata_o;
  logic        m_req_o;
  logic        m_gnt_i;
  logic [31:0] m_addr_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_wdata_o;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        busy_o;
  logic        err_o;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];

  int errors = 0;
  int checks = 0;

  cgra_obi_master_cut #(.MAX_OUTSTANDING(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_req_i    (s_req_i),
    .s_gnt_o    (s_gnt_o),
    .s_addr_i   (s_addr_i),
    .s_we_i     (s_we_i),
    .s_be_i     (s_be_i),
    .s_wdata_i  (s_wdata_i),
    .s_rvalid_o (s_rvalid_o),
    .s_rdata_o  (s_rdata_o),
    .m_req_o    (m_req_o),
    .m_gnt_i    (m_gnt_i),
    .m_addr_o   (m_addr_o),
    .m_we_o     (m_we_o),
    .m_be_o     (m_be_o),
    .m_wdata_o  (m_wdata_o),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata);
    s_req_i   = 1'b1;
    s_addr_i  = addr;
    s_we_i    = we;
    s_be_i    = be;
    s_wdata_i = wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      s_req_i    = 1'b0;
      m_rvalid_i = 1'b0;
    end
  endtask

  // Scoreboard: pop before push, since a grant or response seen now surfaces a cycle later.
  always @(negedge clk_i) begin
    if (rst_i) begin
      req_q.delete();
      rsp_q.delete();
    end else begin
      if (m_req_o && m_gnt_i) begin
        check("req_q_nonempty", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          req_t exp_req;
          exp_req = req_q.pop_front();
          check("m_addr", m_addr_o, exp_req.addr);
          check("m_we", 32'(m_we_o), 32'(exp_req.we));
          check("m_be", 32'(m_be_o), 32'(exp_req.be));
          check("m_wdata", m_wdata_o, exp_req.wdata);
        end
      end
      if (s_rvalid_o) begin
        check("rsp_q_nonempty", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          check("s_rdata", s_rdata_o, rsp_q.pop_front());
        end
      end
      if (s_req_i && s_gnt_o) begin
        req_q.push_back('{addr: s_addr_i, we: s_we_i, be: s_be_i, wdata: s_wdata_i});
      end
      if (m_rvalid_i) begin
        rsp_q.push_back(m_rdata_i);
      end
    end
  end

  initial begin
    int n_gnt;

    rst_i      = 1'b1;
    s_req_i    = 1'b1;
    s_addr_i   = 32'h0000_1234;
    s_we_i     = 1'b0;
    s_be_i     = 4'hF;
    s_wdata_i  = '0;
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;

    // Reset values; grant is forced low while reset is high.
    cyc();
    settle();
    check("rst_s_gnt", 32'(s_gnt_o), 32'd0);
    check("rst_m_req", 32'(m_req_o), 32'd0);
    check("rst_s_rvalid", 32'(s_rvalid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_m_addr", m_addr_o, 32'd0);
    check("rst_m_wdata", m_wdata_o, 32'd0);
    check("rst_s_rdata", s_rdata_o, 32'd0);
    cyc();
    rst_i   = 1'b0;
    s_req_i = 1'b0;
    m_gnt_i = 1'b1;

    // Single read, response two cycles after the downstream grant.
    cyc();
    drive_req(32'h0001_0040, 1'b0, 4'hF, 32'h0);
    settle();
    check("rd_s_gnt", 32'(s_gnt_o), 32'd1);
    check("rd_m_req_before", 32'(m_req_o), 32'd0);
    cyc();
    s_req_i = 1'b0;
    settle();
    check("rd_m_req_after", 32'(m_req_o), 32'd1);
    check("rd_m_addr", m_addr_o, 32'h0001_0040);
    cyc();
    settle();
    check("rd_busy_wait", 32'(busy_o), 32'd1);
    cyc();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'hDEAD_BEEF;
    settle();
    check("rd_s_rvalid_early", 32'(s_rvalid_o), 32'd0);
    cyc();
    m_rvalid_i = 1'b0;
    settle();
    check("rd_s_rvalid", 32'(s_rvalid_o), 32'd1);
    check("rd_s_rdata", s_rdata_o, 32'hDEAD_BEEF);
    cyc();
    settle();
    check("rd_busy_done", 32'(busy_o), 32'd0);

    // Eight back-to-back writes, each response one cycle after its downstream handshake.
    n_gnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k < 8) begin
        drive_req(32'h0000_0100 + 32'(4 * k), 1'b1, 4'hF, 32'hA000_0000 + 32'(k));
      end else begin
        s_req_i = 1'b0;
      end
      m_rvalid_i = (k >= 2);
      m_rdata_i  = 32'h0000_00B0 + 32'(k);
      settle();
      if (k < 8) begin
        check("st_s_gnt", 32'(s_gnt_o), 32'd1);
      end
      if (s_req_i && s_gnt_o) n_gnt++;
    end
    check("st_grants_9cyc", 32'(n_gnt), 32'd8);
    idle(1);
    settle();
    check("st_busy_tail", 32'(busy_o), 32'd1);
    idle(1);
    settle();
    check("st_busy_done", 32'(busy_o), 32'd0);
    check("st_err", 32'(err_o), 32'd0);

    // Credit stall: two in flight with responses withheld, then same-cycle credit reuse.
    cyc();
    drive_req(32'h0000_0200, 1'b0, 4'h3, 32'h0);
    settle();
    check("cr_gnt0", 32'(s_gnt_o), 32'd1);
    cyc();
    drive_req(32'h0000_0204, 1'b0, 4'hC, 32'h0);
    settle();
    check("cr_gnt1", 32'(s_gnt_o), 32'd1);
    cyc();
    drive_req(32'h0000_0208, 1'b0, 4'h1, 32'h0);
    settle();
    check("cr_stall_a", 32'(s_gnt_o), 32'd0);
    cyc();
    settle();
    check("cr_stall_b", 32'(s_gnt_o), 32'd0);
    cyc();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h1111_0000;
    settle();
    check("cr_reuse_gnt", 32'(s_gnt_o), 32'd1);
    cyc();
    s_req_i   = 1'b0;
    m_rdata_i = 32'h1111_0001;
    cyc();
    m_rdata_i = 32'h1111_0002;
    idle(2);
    settle();
    check("cr_busy_done", 32'(busy_o), 32'd0);

    // Downstream backpressure for five cycles with address 0x20 held in the slot.
    cyc();
    m_gnt_i = 1'b0;
    drive_req(32'h0000_0020, 1'b1, 4'hF, 32'hCAFE_0020);
    settle();
    check("bp_first_gnt", 32'(s_gnt_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      drive_req(32'h0000_0024, 1'b1, 4'hF, 32'hCAFE_0024);
      settle();
      check("bp_m_req", 32'(m_req_o), 32'd1);
      check("bp_m_addr", m_addr_o, 32'h0000_0020);
      check("bp_s_gnt", 32'(s_gnt_o), 32'd0);
    end
    cyc();
    s_req_i = 1'b0;
    m_gnt_i = 1'b1;
    cyc();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h0000_2020;
    idle(2);
    settle();
    check("bp_busy_done", 32'(busy_o), 32'd0);
    check("bp_err", 32'(err_o), 32'd0);

    // Protocol error: a response with nothing outstanding.
    cyc();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h5A5A_5A5A;
    settle();
    check("pe_err_before", 32'(err_o), 32'd0);
    cyc();
    m_rvalid_i = 1'b0;
    settle();
    check("pe_err_set", 32'(err_o), 32'd1);
    check("pe_fwd_valid", 32'(s_rvalid_o), 32'd1);
    check("pe_fwd_data", s_rdata_o, 32'h5A5A_5A5A);
    cyc();
    settle();
    check("pe_err_held", 32'(err_o), 32'd1);
    check("pe_cnt_zero_busy", 32'(busy_o), 32'd0);
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    settle();
    check("pe_err_cleared", 32'(err_o), 32'd0);

    // Reset while one request sits in the slot and one is outstanding.
    cyc();
    drive_req(32'h0000_0300, 1'b0, 4'hF, 32'h0);
    cyc();
    drive_req(32'h0000_0304, 1'b0, 4'hF, 32'h0);
    cyc();
    m_gnt_i = 1'b0;
    settle();
    check("mr_busy_pre", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    settle();
    check("mr_gnt_in_rst", 32'(s_gnt_o), 32'd0);
    cyc();
    rst_i   = 1'b0;
    s_req_i = 1'b0;
    settle();
    check("mr_m_req", 32'(m_req_o), 32'd0);
    check("mr_busy", 32'(busy_o), 32'd0);
    check("mr_s_rvalid", 32'(s_rvalid_o), 32'd0);
    cyc();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h0BAD_0BAD;
    cyc();
    m_rvalid_i = 1'b0;
    settle();
    check("mr_stray_err", 32'(err_o), 32'd1);
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i   = 1'b0;
    m_gnt_i = 1'b1;
    idle(2);
    settle();
    check("end_err", 32'(err_o), 32'd0);
    check("end_req_q_empty", 32'(req_q.size()), 32'd0);
    check("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cgra_obi_master_cut.md
CGRA_OBI_MASTER_CUT -- requirements
Module: cgra_obi_master_cut

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of transactions in flight (slot plus downstream-granted); legal range 1..15.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have the upstream (CGRA master side) request ports:
- s_req_i  input  1
- s_gnt_o  output  1
- s_addr_i  input  32
- s_we_i  input  1
- s_be_i  input  4
- s_wdata_i  input  32
REQ-005 SHALL have the upstream response ports:
- s_rvalid_o  output  1
- s_rdata_o  output  32
REQ-006 SHALL have the downstream (external bus master port) request ports:
- m_req_o  output  1
- m_gnt_i  input  1
- m_addr_o  output  32
- m_we_o  output  1
- m_be_o  output  4
- m_wdata_o  output  32
REQ-007 SHALL have the downstream response ports:
- m_rvalid_i  input  1
- m_rdata_i  input  32
REQ-008 SHALL have the status ports:
- busy_o  output  1  any transaction in slot, outstanding, or response pending.
- err_o  output  1  sticky protocol error.

Function
REQ-009 SHALL hold one request slot (valid flag, addr, we, be, wdata) and an outstanding counter cnt of width clog2(MAX_OUTSTANDING+1).
REQ-010 SHALL define inflight = slot_valid + cnt.
REQ-011 SHALL drive s_gnt_o = s_req_i AND (NOT slot_valid OR m_gnt_i) AND (inflight < MAX_OUTSTANDING OR m_rvalid_i), combinationally.
REQ-012 SHALL load the slot from the s_* request fields on any cycle with s_req_i AND s_gnt_o; the request appears on m_* exactly one cycle after its upstream grant.
REQ-013 SHALL drive m_req_o = slot_valid, and m_addr_o/m_we_o/m_be_o/m_wdata_o from the slot; these stay stable while m_req_o is high and m_gnt_i is low.
REQ-014 SHALL clear slot_valid on m_req_o AND m_gnt_i unless the slot is reloaded in the same cycle, so back-to-back requests sustain one transaction per cycle.
REQ-015 SHALL increment cnt on a downstream handshake (m_req_o AND m_gnt_i) and decrement it on m_rvalid_i; when both occur in one cycle, cnt SHALL be unchanged.
REQ-016 SHALL register responses: s_rvalid_o and s_rdata_o equal the previous cycle's m_rvalid_i and m_rdata_i, a fixed latency of 1 cycle.
REQ-017 SHALL preserve response order; there is no reordering and no response storage beyond one register stage.
REQ-018 SHALL treat m_rvalid_i with cnt = 0 as a protocol error:
- err_o is set and held until reset;
- the response is still forwarded upstream;
- cnt stays at 0 (no wrap-around).
REQ-019 SHALL also set err_o if cnt would exceed MAX_OUTSTANDING; by construction of REQ-011 this is unreachable, and the bench asserts it never fires.
REQ-020 SHALL drive busy_o = slot_valid OR (cnt != 0) OR s_rvalid_o.
REQ-021 SHALL, when inflight = MAX_OUTSTANDING and m_rvalid_i = 1 in the same cycle, grant a new upstream request in that cycle (credit returned and reused in the same cycle).

Reset
REQ-022 SHALL, when rst_i is sampled high, clear slot_valid, cnt, s_rvalid_o and err_o on the same clock edge.
REQ-023 SHALL hold the reset values m_req_o=0, s_rvalid_o=0, busy_o=0, err_o=0, m_*/s_rdata_o data=0; s_gnt_o is combinational and is forced to 0 while rst_i=1.
REQ-024 SHALL, on reset mid-operation, discard all in-flight state; the downstream is reset concurrently, and any stray m_rvalid_i after reset sets err_o per REQ-018.

Verification
REQ-025 Single read:
- stimulus: s_req_i with addr=0x0001_0040, we=0; m_gnt_i=1; m_rvalid_i returned 2 cycles after grant with rdata=0xDEAD_BEEF;
- required: m_req_o rises 1 cycle after s_gnt_o; s_rvalid_o=1 with s_rdata_o=0xDEAD_BEEF 1 cycle after m_rvalid_i; busy_o returns to 0.
REQ-026 Streaming with MAX_OUTSTANDING=2:
- stimulus: 8 back-to-back writes; m_gnt_i=1 always; responses returned after 1 cycle;
- required: 8 grants in 9 cycles; wdata order preserved on m_wdata_o.
REQ-027 Credit stall:
- stimulus: MAX_OUTSTANDING=2; responses withheld;
- required: after 2 grants s_gnt_o=0 with s_req_i=1; the cycle m_rvalid_i=1 is driven, s_gnt_o=1 (REQ-021).
REQ-028 Downstream backpressure:
- stimulus: m_gnt_i=0 for 5 cycles with the slot holding addr=0x20;
- required: m_addr_o stable at 0x20; m_req_o held high; s_gnt_o=0 throughout.
REQ-029 Protocol error:
- stimulus: m_rvalid_i=1 with cnt=0;
- required: err_o=1 from the next cycle onward, cnt=0, response forwarded; rst_i=1 clears err_o.
REQ-030 Mid-operation reset:
- stimulus: rst_i asserted with slot_valid=1 and cnt=1;
- required: on the next cycle m_req_o=0, busy_o=0, s_rvalid_o=0.
